alu_sequencer: RTL and testbench
================================

Name: alu_sequencer

Overview:
- Instruction-cycle controller that drives the accumulator ALU. It generates `alu_ena` and the memory/register strobes for each 3-bit opcode, and consumes the ALU `zero` flag.
- Sits between the instruction register and the datapath: PC, IR, accumulator, ALU, data-bus driver and RAM/ROM.
- Each instruction takes 8 clock states, T0..T7. HLT parks the machine.

Parameters:
- HALT_STICKY, 1: 1 = the HALT state is left only by reset; 0 = HALT returns to IDLE when `ena` is low.
- SKIP_INCS, 2: number of `inc_pc` pulses SKZ issues when `zero` = 1, equal to the instruction length in bytes. Legal values are 1..3.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- ena  in  1  run enable, sampled every clock.
- opcode  in  3  IR[15:13]. Valid from T2 onward.
- zero  in  1  ALU zero flag (accumulator == 0).
- alu_ena  out  1  ALU register-update enable.
- inc_pc  out  1  PC += 1.
- load_pc  out  1  PC <= IR address field.
- load_ir  out  1  IR captures the data bus (high byte, then low byte).
- load_acc  out  1  accumulator <= alu_out.
- rd  out  1  memory read strobe.
- wr  out  1  memory write strobe.
- datactl_ena  out  1  drive alu_out onto the data bus.
- halt  out  1  machine halted.
- fetch  out  1  high during T0..T3.
- instr_done  out  1  one-cycle pulse in T7.

Behaviour:
- Opcode encoding: HLT=000, SKZ=001, ADD=010, ANDD=011, XORR=100, LDA=101, STO=110, JMP=111.
- All outputs are registered. A value listed for a state is present during that state, updated on the same edge as the state register. Unlisted outputs are 0.
- Reset (`rst_n` low, asynchronous): state=IDLE, all outputs 0, `opcode_q`=000, `zero_q`=0. The first edge after release is evaluated normally.
- States: IDLE, T0..T7, HALT.
- IDLE: all outputs 0.
  - ena=1 -> T0.
  - ena=0 -> stay in IDLE.
- Any state Tn with ena=0 at a clock edge -> IDLE; the instruction aborts and no further strobes are issued.
- HALT has priority over the ena abort rule.
- T0: rd, load_ir, inc_pc, fetch.
- T1: rd, load_ir, inc_pc, fetch.
- T2: fetch. `opcode_q` <= opcode at the end of T2; all later decoding uses `opcode_q`.
- T3: fetch.
  - HLT: next state HALT.
  - ADD/ANDD/XORR/LDA: rd.
  - STO: alu_ena (ALU registers accum).
  - `zero_q` <= zero at the end of T3.
- T4:
  - ADD/ANDD/XORR/LDA: rd, alu_ena (ALU samples data and accum at the end of T4).
  - STO: datactl_ena.
- T5:
  - ADD/ANDD/XORR/LDA: rd, load_acc.
  - STO: datactl_ena, wr.
  - JMP: load_pc.
  - SKZ with zero_q=1: inc_pc.
- T6:
  - STO: datactl_ena. The bus is held one cycle past `wr` for hold time.
  - SKZ with zero_q=1 and SKIP_INCS>=2: inc_pc.
- T7: instr_done.
  - SKZ with zero_q=1 and SKIP_INCS==3: inc_pc.
  - Next state is T0 if ena=1.
- HALT: halt=1; all other outputs 0.
  - HALT_STICKY=1: stays in HALT until rst_n.
  - HALT_STICKY=0: ena=0 -> IDLE with halt cleared.
- Exclusivity invariants:
  - rd and wr are never high together.
  - wr=1 implies datactl_ena=1.
  - load_pc and inc_pc are never high together.
  - load_ir only in T0/T1.
- Opcode changes after T2 have no effect. A zero change after T3 has no effect on the SKZ decision.
- Reset mid-instruction (any Tn, HALT): all outputs drop to 0 immediately (asynchronous), and execution resumes from IDLE.

Test Plan:
- Reset then ena=1, opcode=LDA (101) → IDLE→T0 next edge; rd=1 in T0/T1 and T3–T5; alu_ena=1 only in T4; load_acc=1 only in T5; instr_done in T7; T0 again on cycle 9.
- Opcode=STO (110) → alu_ena in T3; datactl_ena in T4, T5 and T6; wr=1 only in T5; rd=0 throughout T3–T7.
- SKZ (001) with zero=1 at T3, SKIP_INCS=2 → inc_pc in T5 and T6 (4 inc_pc pulses per instruction in total). Repeat with zero=0 → no inc_pc after T1. Toggle zero in T4 → decision unchanged.
- JMP (111) → load_pc=1 in T5 only; inc_pc never high in the same cycle. Drive opcode to 000 during T4 → still decoded as JMP, no halt.
- HLT (000), HALT_STICKY=1 → halt=1 from the cycle after T3, stays high with ena toggled 0/1 for 20 cycles; rst_n pulse low → halt=0 asynchronously, then IDLE.
- ADD with ena dropped during T4 → next state IDLE, load_acc never asserted. rst_n low mid-T5 of STO → wr and datactl_ena fall without waiting for a clock edge.

Source files
------------

// File: rtl/alu_sequencer.sv
// alu_sequencer: instruction-cycle controller for the accumulator ALU.
// Every instruction walks T0..T7; HLT parks the machine in HALT.
// Ports:
//   clk, rst_n (async, active low), ena (run enable)
//   opcode (IR[15:13], valid from T2), zero (ALU accumulator == 0)
//   alu_ena, inc_pc, load_pc, load_ir, load_acc, rd, wr, datactl_ena,
//   halt, fetch, instr_done -- all registered strobes
module alu_sequencer #(
  parameter bit          HALT_STICKY = 1'b1,
  parameter int unsigned SKIP_INCS   = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [2:0] opcode,
  input  logic       zero,
  output logic       alu_ena,
  output logic       inc_pc,
  output logic       load_pc,
  output logic       load_ir,
  output logic       load_acc,
  output logic       rd,
  output logic       wr,
  output logic       datactl_ena,
  output logic       halt,
  output logic       fetch,
  output logic       instr_done
);

  typedef enum logic [3:0] {
    S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
  } state_e;

  typedef enum logic [2:0] {
    OP_HLT  = 3'b000,
    OP_SKZ  = 3'b001,
    OP_ADD  = 3'b010,
    OP_ANDD = 3'b011,
    OP_XORR = 3'b100,
    OP_LDA  = 3'b101,
    OP_STO  = 3'b110,
    OP_JMP  = 3'b111
  } op_e;

  typedef struct packed {
    logic alu_ena;
    logic inc_pc;
    logic load_pc;
    logic load_ir;
    logic load_acc;
    logic rd;
    logic wr;
    logic datactl_ena;
    logic halt;
    logic fetch;
    logic instr_done;
  } out_t;

  state_e state_q, state_d;
  op_e    opcode_q, opcode_d;
  logic   zero_q, zero_d;
  out_t   out_q, out_d;
  logic   is_alu_op;
  logic   skz_hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      opcode_q <= OP_HLT;
      zero_q   <= 1'b0;
      out_q    <= '0;
    end else begin
      state_q  <= state_d;
      opcode_q <= opcode_d;
      zero_q   <= zero_d;
      out_q    <= out_d;
    end
  end

  // Next state plus the opcode/zero latches.
  always_comb begin
    state_d  = state_q;
    opcode_d = opcode_q;
    zero_d   = zero_q;
    case (state_q)
      S_IDLE: state_d = ena ? S_T0 : S_IDLE;
      S_T0:   state_d = ena ? S_T1 : S_IDLE;
      S_T1:   state_d = ena ? S_T2 : S_IDLE;
      S_T2: begin
        opcode_d = op_e'(opcode);
        state_d  = ena ? S_T3 : S_IDLE;
      end
      S_T3: begin
        zero_d = zero;
        // HLT wins over an ena abort.
        if (opcode_q == OP_HLT) state_d = S_HALT;
        else                    state_d = ena ? S_T4 : S_IDLE;
      end
      S_T4:   state_d = ena ? S_T5 : S_IDLE;
      S_T5:   state_d = ena ? S_T6 : S_IDLE;
      S_T6:   state_d = ena ? S_T7 : S_IDLE;
      S_T7:   state_d = ena ? S_T0 : S_IDLE;
      S_HALT: if (!HALT_STICKY && !ena) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are registered, so they are decoded from the state being
  // entered, using the opcode/zero values that will be held in it.
  always_comb begin
    out_d     = '0;
    is_alu_op = (opcode_d == OP_ADD) || (opcode_d == OP_ANDD) ||
                (opcode_d == OP_XORR) || (opcode_d == OP_LDA);
    skz_hit   = (opcode_d == OP_SKZ) && zero_d;
    case (state_d)
      S_T0, S_T1: begin
        out_d.rd      = 1'b1;
        out_d.load_ir = 1'b1;
        out_d.inc_pc  = 1'b1;
        out_d.fetch   = 1'b1;
      end
      S_T2: out_d.fetch = 1'b1;
      S_T3: begin
        out_d.fetch   = 1'b1;
        out_d.rd      = is_alu_op;
        out_d.alu_ena = (opcode_d == OP_STO);
      end
      S_T4: begin
        out_d.rd          = is_alu_op;
        out_d.alu_ena     = is_alu_op;
        out_d.datactl_ena = (opcode_d == OP_STO);
      end
      S_T5: begin
        out_d.rd          = is_alu_op;
        out_d.load_acc    = is_alu_op;
        out_d.datactl_ena = (opcode_d == OP_STO);
        out_d.wr          = (opcode_d == OP_STO);
        out_d.load_pc     = (opcode_d == OP_JMP);
        out_d.inc_pc      = skz_hit;
      end
      S_T6: begin
        // Bus held one cycle past wr for hold time.
        out_d.datactl_ena = (opcode_d == OP_STO);
        out_d.inc_pc      = skz_hit && (SKIP_INCS >= 2);
      end
      S_T7: begin
        out_d.instr_done = 1'b1;
        out_d.inc_pc     = skz_hit && (SKIP_INCS == 3);
      end
      S_HALT: out_d.halt = 1'b1;
      default: ;
    endcase
  end

  assign alu_ena     = out_q.alu_ena;
  assign inc_pc      = out_q.inc_pc;
  assign load_pc     = out_q.load_pc;
  assign load_ir     = out_q.load_ir;
  assign load_acc    = out_q.load_acc;
  assign rd          = out_q.rd;
  assign wr          = out_q.wr;
  assign datactl_ena = out_q.datactl_ena;
  assign halt        = out_q.halt;
  assign fetch       = out_q.fetch;
  assign instr_done  = out_q.instr_done;

endmodule

// File: tb/tb_alu_sequencer.sv
// Testbench for alu_sequencer: two instances (sticky halt / 2 skips and
// non-sticky halt / 3 skips) share stimulus and are compared every cycle
// against an instruction-level reference model.
module tb_alu_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       ena = 1'b0;
  logic [2:0] opcode = 3'b000;
  logic       zero = 1'b0;

  logic a_alu_ena, a_inc_pc, a_load_pc, a_load_ir, a_load_acc, a_rd, a_wr;
  logic a_datactl_ena, a_halt, a_fetch, a_instr_done;
  logic b_alu_ena, b_inc_pc, b_load_pc, b_load_ir, b_load_acc, b_rd, b_wr;
  logic b_datactl_ena, b_halt, b_fetch, b_instr_done;
  logic [10:0] v0, v1;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  alu_sequencer #(.HALT_STICKY(1'b1), .SKIP_INCS(2)) u0 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .opcode(opcode), .zero(zero),
    .alu_ena(a_alu_ena), .inc_pc(a_inc_pc), .load_pc(a_load_pc),
    .load_ir(a_load_ir), .load_acc(a_load_acc), .rd(a_rd), .wr(a_wr),
    .datactl_ena(a_datactl_ena), .halt(a_halt), .fetch(a_fetch),
    .instr_done(a_instr_done)
  );

  alu_sequencer #(.HALT_STICKY(1'b0), .SKIP_INCS(3)) u1 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .opcode(opcode), .zero(zero),
    .alu_ena(b_alu_ena), .inc_pc(b_inc_pc), .load_pc(b_load_pc),
    .load_ir(b_load_ir), .load_acc(b_load_acc), .rd(b_rd), .wr(b_wr),
    .datactl_ena(b_datactl_ena), .halt(b_halt), .fetch(b_fetch),
    .instr_done(b_instr_done)
  );

  // Bit order: alu_ena inc_pc load_pc load_ir load_acc rd wr datactl halt fetch done
  assign v0 = {a_alu_ena, a_inc_pc, a_load_pc, a_load_ir, a_load_acc, a_rd,
               a_wr, a_datactl_ena, a_halt, a_fetch, a_instr_done};
  assign v1 = {b_alu_ena, b_inc_pc, b_load_pc, b_load_ir, b_load_acc, b_rd,
               b_wr, b_datactl_ena, b_halt, b_fetch, b_instr_done};

  // Reference model: mode 0 idle, 1 running (phase m_t), 2 halted.
  int          m_mode[2];
  int          m_t[2];
  logic [2:0]  m_op[2];
  logic        m_zq[2];
  bit          m_sticky[2] = '{1'b1, 1'b0};
  int          m_skip[2]   = '{2, 3};

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_mode[k] = 0; m_t[k] = 0; m_op[k] = 3'b000; m_zq[k] = 1'b0;
    end
  endtask

  task automatic model_step(input int k, input logic e, input logic [2:0] o,
                            input logic z);
    case (m_mode[k])
      0: if (e) begin m_mode[k] = 1; m_t[k] = 0; end
      1: begin
        if (m_t[k] == 2) m_op[k] = o;
        if (m_t[k] == 3) m_zq[k] = z;
        if (m_t[k] == 3 && m_op[k] == 3'b000) m_mode[k] = 2;
        else if (!e)                          m_mode[k] = 0;
        else                                  m_t[k] = (m_t[k] + 1) % 8;
      end
      default: if (!m_sticky[k] && !e) m_mode[k] = 0;
    endcase
  endtask

  function automatic logic [10:0] expv(input int k);
    logic [10:0] e;
    int t;
    logic [2:0] op;
    bit alu, sto, skz_hit;
    e = '0;
    if (m_mode[k] == 2) e[2] = 1'b1;
    else if (m_mode[k] == 1) begin
      t = m_t[k]; op = m_op[k];
      alu = (op >= 3'd2 && op <= 3'd5);
      sto = (op == 3'd6);
      skz_hit = (op == 3'd1) && m_zq[k];
      e[1]  = (t < 4);                                    // fetch
      e[7]  = (t < 2);                                    // load_ir
      e[5]  = (t < 2) || (alu && t >= 3 && t <= 5);       // rd
      e[9]  = (t < 2) || (skz_hit && t >= 5 && t < 5 + m_skip[k]); // inc_pc
      e[10] = (alu && t == 4) || (sto && t == 3);         // alu_ena
      e[6]  = alu && t == 5;                              // load_acc
      e[3]  = sto && t >= 4 && t <= 6;                    // datactl_ena
      e[4]  = sto && t == 5;                              // wr
      e[8]  = (op == 3'd7) && t == 5;                     // load_pc
      e[0]  = (t == 7);                                   // instr_done
    end
    return e;
  endfunction

  // One clock: inputs sampled as they stand, model advanced, outputs settle.
  task automatic cyc();
    logic e, z;
    logic [2:0] o;
    e = ena; o = opcode; z = zero;
    @(posedge clk);
    if (rst_n) for (int k = 0; k < 2; k++) model_step(k, e, o, z);
    #1;
  endtask

  task automatic test_reset();
    ena = 1'b0; opcode = 3'b000; zero = 1'b0;
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if ({v0, v1} !== 22'd0) begin
      n_fail++; $display("FAIL reset_state got=%b exp=%b", {v0, v1}, 22'd0);
    end
    @(posedge clk); #1;
    n_checks++;
    if ({v0, v1} !== 22'd0) begin
      n_fail++; $display("FAIL reset_hold got=%b exp=%b", {v0, v1}, 22'd0);
    end
    @(negedge clk); rst_n = 1'b1;
    cyc();
    n_checks++;
    if ({v0, v1} !== {expv(0), expv(1)}) begin
      n_fail++; $display("FAIL reset_idle got=%b exp=%b", {v0, v1}, {expv(0), expv(1)});
    end
  endtask

  task automatic test_lda();
    int alu_cnt = 0;
    ena = 1'b1; opcode = 3'b101; zero = 1'($urandom_range(0, 1));
    for (int c = 1; c <= 10; c++) begin
      cyc();
      if (c <= 8 && a_alu_ena) alu_cnt++;
      n_checks++;
      if ({v0, v1} !== {expv(0), expv(1)}) begin
        n_fail++; $display("FAIL lda cyc=%0d got=%b exp=%b", c, {v0, v1}, {expv(0), expv(1)});
      end
      if (c == 9) begin
        n_checks++;
        if ({a_load_ir, a_fetch, a_rd} !== 3'b111) begin
          n_fail++; $display("FAIL lda_t0_again got=%b exp=111", {a_load_ir, a_fetch, a_rd});
        end
      end
    end
    n_checks++;
    if (alu_cnt !== 1) begin
      n_fail++; $display("FAIL lda_alu_ena_count got=%0d exp=1", alu_cnt);
    end
    ena = 1'b0; cyc();
  endtask

  task automatic test_sto();
    int wr_cnt = 0, rd_cnt = 0;
    ena = 1'b1; opcode = 3'b110;
    for (int c = 1; c <= 8; c++) begin
      cyc();
      wr_cnt += int'(a_wr); rd_cnt += int'(a_rd);
      n_checks++;
      if ({v0, v1} !== {expv(0), expv(1)}) begin
        n_fail++; $display("FAIL sto cyc=%0d got=%b exp=%b", c, {v0, v1}, {expv(0), expv(1)});
      end
    end
    n_checks++;
    if (wr_cnt !== 1 || rd_cnt !== 2) begin
      n_fail++; $display("FAIL sto_counts got wr=%0d rd=%0d exp wr=1 rd=2", wr_cnt, rd_cnt);
    end
    ena = 1'b0; cyc();
  endtask

  task automatic test_skz();
    int inc0, inc1, exp0, exp1;
    for (int v = 0; v < 3; v++) begin   // v=0 zero=1, v=1 zero=0, v=2 zero toggled in T4
      inc0 = 0; inc1 = 0;
      ena = 1'b1; opcode = 3'b001; zero = (v != 1);
      for (int c = 1; c <= 8; c++) begin
        cyc();
        inc0 += int'(a_inc_pc); inc1 += int'(b_inc_pc);
        n_checks++;
        if ({v0, v1} !== {expv(0), expv(1)}) begin
          n_fail++; $display("FAIL skz v=%0d cyc=%0d got=%b exp=%b", v, c, {v0, v1}, {expv(0), expv(1)});
        end
        if (v == 2 && c == 5) zero = 1'b0;
      end
      exp0 = (v == 1) ? 2 : 4;
      exp1 = (v == 1) ? 2 : 5;
      n_checks++;
      if (inc0 !== exp0 || inc1 !== exp1) begin
        n_fail++; $display("FAIL skz_inc_count v=%0d got=%0d/%0d exp=%0d/%0d", v, inc0, inc1, exp0, exp1);
      end
      ena = 1'b0; cyc();
    end
  endtask

  task automatic test_jmp();
    int lp_cnt = 0, bad = 0;
    ena = 1'b1; opcode = 3'b111;
    for (int c = 1; c <= 8; c++) begin
      cyc();
      lp_cnt += int'(a_load_pc);
      if ((a_load_pc && a_inc_pc) || a_halt) bad++;
      n_checks++;
      if ({v0, v1} !== {expv(0), expv(1)}) begin
        n_fail++; $display("FAIL jmp cyc=%0d got=%b exp=%b", c, {v0, v1}, {expv(0), expv(1)});
      end
      if (c == 5) opcode = 3'b000;
    end
    n_checks++;
    if (lp_cnt !== 1 || bad !== 0) begin
      n_fail++; $display("FAIL jmp_load_pc got=%0d bad=%0d exp=1 bad=0", lp_cnt, bad);
    end
    ena = 1'b0; cyc();
  endtask

  task automatic test_abort();
    int la_cnt = 0;
    ena = 1'b1; opcode = 3'b010;
    for (int c = 1; c <= 9; c++) begin
      cyc();
      la_cnt += int'(a_load_acc);
      n_checks++;
      if ({v0, v1} !== {expv(0), expv(1)}) begin
        n_fail++; $display("FAIL abort cyc=%0d got=%b exp=%b", c, {v0, v1}, {expv(0), expv(1)});
      end
      if (c == 5) ena = 1'b0;
    end
    n_checks++;
    if (la_cnt !== 0) begin
      n_fail++; $display("FAIL abort_load_acc got=%0d exp=0", la_cnt);
    end
  endtask

  task automatic test_halt();
    int halt_lo = 0;
    ena = 1'b1; opcode = 3'b000;
    for (int c = 1; c <= 25; c++) begin
      cyc();
      if (c >= 5 && !a_halt) halt_lo++;
      n_checks++;
      if ({v0, v1} !== {expv(0), expv(1)}) begin
        n_fail++; $display("FAIL halt cyc=%0d got=%b exp=%b", c, {v0, v1}, {expv(0), expv(1)});
      end
      if (c >= 5) ena = ~ena;
    end
    n_checks++;
    if (halt_lo !== 0) begin
      n_fail++; $display("FAIL halt_sticky low_cycles=%0d exp=0", halt_lo);
    end
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if (a_halt !== 1'b0 || {v0, v1} !== 22'd0) begin
      n_fail++; $display("FAIL halt_async_clear got=%b exp=%b", {v0, v1}, 22'd0);
    end
    ena = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    cyc();
    n_checks++;
    if ({v0, v1} !== {expv(0), expv(1)}) begin
      n_fail++; $display("FAIL halt_to_idle got=%b exp=%b", {v0, v1}, {expv(0), expv(1)});
    end
  endtask

  task automatic test_reset_mid();
    ena = 1'b1; opcode = 3'b110;
    for (int c = 1; c <= 6; c++) begin
      cyc();
      n_checks++;
      if ({v0, v1} !== {expv(0), expv(1)}) begin
        n_fail++; $display("FAIL rstmid cyc=%0d got=%b exp=%b", c, {v0, v1}, {expv(0), expv(1)});
      end
    end
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if ({a_wr, a_datactl_ena, b_wr, b_datactl_ena} !== 4'b0000 || {v0, v1} !== 22'd0) begin
      n_fail++; $display("FAIL rstmid_async got=%b exp=%b", {v0, v1}, 22'd0);
    end
    ena = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    cyc();
  endtask

  task automatic test_random();
    int viol = 0;
    for (int c = 0; c < 400; c++) begin
      ena    = ($urandom_range(0, 9) != 0);
      opcode = 3'($urandom_range(0, 7));
      zero   = 1'($urandom_range(0, 1));
      if (m_mode[0] == 2 && $urandom_range(0, 3) == 0) begin
        #2 rst_n = 1'b0;
        model_reset();
        @(negedge clk); rst_n = 1'b1;
      end
      cyc();
      if ((a_rd && a_wr) || (a_wr && !a_datactl_ena) || (a_load_pc && a_inc_pc) ||
          (b_rd && b_wr) || (b_wr && !b_datactl_ena) || (b_load_pc && b_inc_pc))
        viol++;
      n_checks++;
      if ({v0, v1} !== {expv(0), expv(1)}) begin
        n_fail++; $display("FAIL random cyc=%0d got=%b exp=%b", c, {v0, v1}, {expv(0), expv(1)});
      end
    end
    n_checks++;
    if (viol !== 0) begin
      n_fail++; $display("FAIL random_invariants got=%0d exp=0", viol);
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_lda();
    test_sto();
    test_skz();
    test_jmp();
    test_abort();
    test_halt();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
